// File: rtl/pkg_axi_lite.sv
// Shared AXI-Lite response codes and channel FSM state encodings.
package pkg_axi_lite;

  typedef logic [1:0] resp_t;

  localparam resp_t RESP_OKAY   = 2'b00;
  localparam resp_t RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DELAY,
    W_RESP
  } wr_state_t;

  typedef enum logic [1:0] {
    R_IDLE,
    R_DELAY,
    R_RESP
  } rd_state_t;

endpackage

// File: rtl/axi_lite_lfsr_delay.sv
// 16-bit Galois LFSR producing a bounded per-transaction response delay.
module axi_lite_lfsr_delay #(
  parameter logic [15:0] SEED      = 16'hACE1,
  parameter int unsigned DELAY_MIN = 2,
  parameter int unsigned DELAY_MAX = 17,
  parameter int unsigned CNT_W     = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             accept,
  output logic [CNT_W-1:0] delay_c
);

  localparam int unsigned SPAN = DELAY_MAX - DELAY_MIN + 1;
  localparam logic [15:0] TAPS = 16'hB400;

  logic [15:0] lfsr_q;

  // Advance one step per accepted transaction; a nonzero seed never reaches zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q <= SEED;
    end else if (accept) begin
      lfsr_q <= {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? TAPS : 16'h0000);
    end
  end

  assign delay_c = CNT_W'(DELAY_MIN + (32'(lfsr_q) % SPAN));

endmodule

// File: rtl/axi_lite_slave_mem.sv
// AXI-Lite slave backed by a word register memory with randomized response latency.
module axi_lite_slave_mem
  import pkg_axi_lite::*;
#(
  parameter int unsigned                  AXI_DATA_WIDTH  = 32,
  parameter int unsigned                  AXI_ADDR_WIDTH  = 32,
  parameter logic [AXI_ADDR_WIDTH-1:0]    AXI_ADDR_OFFSET = AXI_ADDR_WIDTH'(32'h0000_0000),
  parameter logic [AXI_ADDR_WIDTH-1:0]    AXI_ADDR_RANGE  = AXI_ADDR_WIDTH'(32'h00FF_FFFF),
  parameter int unsigned                  MEM_DEPTH       = 256,
  parameter int unsigned                  DELAY_MIN       = 2,
  parameter int unsigned                  DELAY_MAX       = 17,
  parameter logic [15:0]                  LFSR_SEED       = 16'hACE1
) (
  input  logic                          aclk,
  input  logic                          areset,
  input  logic [AXI_ADDR_WIDTH-1:0]     s_axi_awaddr,
  input  logic                          s_axi_awvalid,
  output logic                          s_axi_awready,
  input  logic [AXI_DATA_WIDTH-1:0]     s_axi_wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0]   s_axi_wstrb,
  input  logic                          s_axi_wvalid,
  output logic                          s_axi_wready,
  output logic [1:0]                    s_axi_bresp,
  output logic                          s_axi_bvalid,
  input  logic                          s_axi_bready,
  input  logic [AXI_ADDR_WIDTH-1:0]     s_axi_araddr,
  input  logic                          s_axi_arvalid,
  output logic                          s_axi_arready,
  output logic [AXI_DATA_WIDTH-1:0]     s_axi_rdata,
  output logic [1:0]                    s_axi_rresp,
  output logic                          s_axi_rvalid,
  input  logic                          s_axi_rready
);

  localparam int unsigned DW     = AXI_DATA_WIDTH;
  localparam int unsigned AW     = AXI_ADDR_WIDTH;
  localparam int unsigned STRB_W = AXI_DATA_WIDTH / 8;
  localparam int unsigned IDX_W  = $clog2(MEM_DEPTH);
  localparam int unsigned CNT_W  = $clog2(DELAY_MAX + 1);

  logic [DW-1:0] mem_q [MEM_DEPTH];

  // ---------------- write channel state ----------------
  wr_state_t          w_state_q, w_state_d;
  logic               aw_held_q, aw_held_d;
  logic               w_held_q, w_held_d;
  logic [AW-1:0]      awaddr_q, awaddr_d;
  logic [DW-1:0]      wdata_q, wdata_d;
  logic [STRB_W-1:0]  wstrb_q, wstrb_d;
  logic [CNT_W-1:0]   w_cnt_q, w_cnt_d;
  logic               awready_d, wready_d, bvalid_d;
  resp_t              bresp_d;

  logic               aw_fire_c, w_fire_c, w_commit_c, w_in_range_c;
  logic [AW-1:0]      w_addr_c, w_offs_c;
  logic [DW-1:0]      w_data_c;
  logic [STRB_W-1:0]  w_strb_c;
  logic [IDX_W-1:0]   w_idx_c;
  logic [CNT_W-1:0]   w_delay_c;

  // ---------------- read channel state ----------------
  rd_state_t          r_state_q, r_state_d;
  logic [CNT_W-1:0]   r_cnt_q, r_cnt_d;
  logic               arready_d, rvalid_d;
  logic [DW-1:0]      rdata_d;
  resp_t              rresp_d;

  logic               ar_fire_c, r_in_range_c;
  logic [AW-1:0]      r_offs_c;
  logic [IDX_W-1:0]   r_idx_c;
  logic [CNT_W-1:0]   r_delay_c;

  // Commit uses whichever of address/data arrives this cycle, else the held copy.
  assign aw_fire_c    = s_axi_awvalid & s_axi_awready;
  assign w_fire_c     = s_axi_wvalid & s_axi_wready;
  assign w_addr_c     = aw_fire_c ? s_axi_awaddr : awaddr_q;
  assign w_data_c     = w_fire_c ? s_axi_wdata : wdata_q;
  assign w_strb_c     = w_fire_c ? s_axi_wstrb : wstrb_q;
  assign w_offs_c     = w_addr_c - AXI_ADDR_OFFSET;
  assign w_in_range_c = (w_offs_c <= AXI_ADDR_RANGE);
  assign w_idx_c      = w_offs_c[IDX_W+1:2];

  assign ar_fire_c    = s_axi_arvalid & s_axi_arready;
  assign r_offs_c     = s_axi_araddr - AXI_ADDR_OFFSET;
  assign r_in_range_c = (r_offs_c <= AXI_ADDR_RANGE);
  assign r_idx_c      = r_offs_c[IDX_W+1:2];

  axi_lite_lfsr_delay #(
    .SEED      (LFSR_SEED),
    .DELAY_MIN (DELAY_MIN),
    .DELAY_MAX (DELAY_MAX),
    .CNT_W     (CNT_W)
  ) u_wr_delay (
    .clk     (aclk),
    .rst     (areset),
    .accept  (w_commit_c),
    .delay_c (w_delay_c)
  );

  axi_lite_lfsr_delay #(
    .SEED      (~LFSR_SEED),
    .DELAY_MIN (DELAY_MIN),
    .DELAY_MAX (DELAY_MAX),
    .CNT_W     (CNT_W)
  ) u_rd_delay (
    .clk     (aclk),
    .rst     (areset),
    .accept  (ar_fire_c),
    .delay_c (r_delay_c)
  );

  // Write FSM: collect AW and W in any order, commit, count down, present B.
  always_comb begin
    w_state_d  = w_state_q;
    aw_held_d  = aw_held_q;
    w_held_d   = w_held_q;
    awaddr_d   = awaddr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    w_cnt_d    = w_cnt_q;
    awready_d  = s_axi_awready;
    wready_d   = s_axi_wready;
    bvalid_d   = s_axi_bvalid;
    bresp_d    = s_axi_bresp;
    w_commit_c = 1'b0;
    unique case (w_state_q)
      W_IDLE: begin
        if (aw_fire_c) begin
          aw_held_d = 1'b1;
          awaddr_d  = s_axi_awaddr;
        end
        if (w_fire_c) begin
          w_held_d = 1'b1;
          wdata_d  = s_axi_wdata;
          wstrb_d  = s_axi_wstrb;
        end
        awready_d = ~(aw_held_q | aw_fire_c);
        wready_d  = ~(w_held_q | w_fire_c);
        if ((aw_held_q | aw_fire_c) && (w_held_q | w_fire_c)) begin
          w_commit_c = 1'b1;
          aw_held_d  = 1'b0;
          w_held_d   = 1'b0;
          awready_d  = 1'b0;
          wready_d   = 1'b0;
          w_cnt_d    = w_delay_c;
          bresp_d    = w_in_range_c ? RESP_OKAY : RESP_SLVERR;
          w_state_d  = W_DELAY;
        end
      end
      W_DELAY: begin
        if (w_cnt_q == CNT_W'(1)) begin
          bvalid_d  = 1'b1;
          w_state_d = W_RESP;
        end else begin
          w_cnt_d = w_cnt_q - CNT_W'(1);
        end
      end
      W_RESP: begin
        if (s_axi_bready) begin
          bvalid_d  = 1'b0;
          awready_d = 1'b1;
          wready_d  = 1'b1;
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // Write channel registers.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      w_state_q     <= W_IDLE;
      aw_held_q     <= 1'b0;
      w_held_q      <= 1'b0;
      awaddr_q      <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      w_cnt_q       <= '0;
      s_axi_awready <= 1'b0;
      s_axi_wready  <= 1'b0;
      s_axi_bvalid  <= 1'b0;
      s_axi_bresp   <= RESP_OKAY;
    end else begin
      w_state_q     <= w_state_d;
      aw_held_q     <= aw_held_d;
      w_held_q      <= w_held_d;
      awaddr_q      <= awaddr_d;
      wdata_q       <= wdata_d;
      wstrb_q       <= wstrb_d;
      w_cnt_q       <= w_cnt_d;
      s_axi_awready <= awready_d;
      s_axi_wready  <= wready_d;
      s_axi_bvalid  <= bvalid_d;
      s_axi_bresp   <= bresp_d;
    end
  end

  // Read FSM: sample memory on AR, count down, present R until accepted.
  always_comb begin
    r_state_d = r_state_q;
    r_cnt_d   = r_cnt_q;
    arready_d = s_axi_arready;
    rvalid_d  = s_axi_rvalid;
    rdata_d   = s_axi_rdata;
    rresp_d   = s_axi_rresp;
    unique case (r_state_q)
      R_IDLE: begin
        arready_d = 1'b1;
        if (ar_fire_c) begin
          arready_d = 1'b0;
          rdata_d   = r_in_range_c ? mem_q[r_idx_c] : '0;
          rresp_d   = r_in_range_c ? RESP_OKAY : RESP_SLVERR;
          r_cnt_d   = r_delay_c;
          r_state_d = R_DELAY;
        end
      end
      R_DELAY: begin
        if (r_cnt_q == CNT_W'(1)) begin
          rvalid_d  = 1'b1;
          r_state_d = R_RESP;
        end else begin
          r_cnt_d = r_cnt_q - CNT_W'(1);
        end
      end
      R_RESP: begin
        if (s_axi_rready) begin
          rvalid_d  = 1'b0;
          arready_d = 1'b1;
          r_state_d = R_IDLE;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  // Read channel registers.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_state_q     <= R_IDLE;
      r_cnt_q       <= '0;
      s_axi_arready <= 1'b0;
      s_axi_rvalid  <= 1'b0;
      s_axi_rdata   <= '0;
      s_axi_rresp   <= RESP_OKAY;
    end else begin
      r_state_q     <= r_state_d;
      r_cnt_q       <= r_cnt_d;
      s_axi_arready <= arready_d;
      s_axi_rvalid  <= rvalid_d;
      s_axi_rdata   <= rdata_d;
      s_axi_rresp   <= rresp_d;
    end
  end

  // Byte-lane memory write; out-of-window writes are dropped.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      for (int unsigned i = 0; i < MEM_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (w_commit_c && w_in_range_c) begin
      for (int unsigned b = 0; b < STRB_W; b++) begin
        if (w_strb_c[b]) begin
          mem_q[w_idx_c][b*8 +: 8] <= w_data_c[b*8 +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_axi_lite_slave_mem.sv
// Self-checking bench: fixed-delay instance for directed tests, default-delay instance for random traffic.
module tb_axi_lite_slave_mem;
  import pkg_axi_lite::*;

  localparam int          DEPTH = 256;
  localparam int          BOUND = 100;
  localparam logic [31:0] OFF   = 32'h0000_0000;
  localparam logic [31:0] RNG   = 32'h00FF_FFFF;

  logic aclk = 1'b0;
  logic areset = 1'b1;
  logic sel = 1'b0;

  logic [31:0] awaddr = '0, wdata = '0, araddr = '0;
  logic [3:0]  wstrb = '0;
  logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;

  logic [1:0]  awready_i, wready_i, bvalid_i, arready_i, rvalid_i;
  logic [1:0]  bresp_i [2];
  logic [1:0]  rresp_i [2];
  logic [31:0] rdata_i [2];

  logic        awready, wready, bvalid, arready, rvalid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;

  int cyc = 0;
  int n_vec = 0;
  int n_err = 0;

  assign awready = awready_i[sel];
  assign wready  = wready_i[sel];
  assign bvalid  = bvalid_i[sel];
  assign arready = arready_i[sel];
  assign rvalid  = rvalid_i[sel];
  assign bresp   = bresp_i[sel];
  assign rresp   = rresp_i[sel];
  assign rdata   = rdata_i[sel];

  always #5 aclk = ~aclk;
  always @(posedge aclk) cyc <= cyc + 1;

  axi_lite_slave_mem #(.DELAY_MIN(3), .DELAY_MAX(3)) u_fix (
    .aclk(aclk), .areset(areset),
    .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid & ~sel), .s_axi_awready(awready_i[0]),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid & ~sel), .s_axi_wready(wready_i[0]),
    .s_axi_bresp(bresp_i[0]), .s_axi_bvalid(bvalid_i[0]), .s_axi_bready(bready & ~sel),
    .s_axi_araddr(araddr), .s_axi_arvalid(arvalid & ~sel), .s_axi_arready(arready_i[0]),
    .s_axi_rdata(rdata_i[0]), .s_axi_rresp(rresp_i[0]), .s_axi_rvalid(rvalid_i[0]),
    .s_axi_rready(rready & ~sel)
  );

  axi_lite_slave_mem u_rnd (
    .aclk(aclk), .areset(areset),
    .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid & sel), .s_axi_awready(awready_i[1]),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid & sel), .s_axi_wready(wready_i[1]),
    .s_axi_bresp(bresp_i[1]), .s_axi_bvalid(bvalid_i[1]), .s_axi_bready(bready & sel),
    .s_axi_araddr(araddr), .s_axi_arvalid(arvalid & sel), .s_axi_arready(arready_i[1]),
    .s_axi_rdata(rdata_i[1]), .s_axi_rresp(rresp_i[1]), .s_axi_rvalid(rvalid_i[1]),
    .s_axi_rready(rready & sel)
  );

  // Reference model helpers: window membership and word index.
  function automatic bit in_win(input logic [31:0] a);
    return (a - OFF) <= RNG;
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'(((a - OFF) >> 2) % DEPTH);
  endfunction

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic aw_issue(input logic [31:0] a, output int hs);
    int t = 0;
    awaddr = a;
    awvalid = 1'b1;
    while (awready !== 1'b1 && t < BOUND) begin step(); t++; end
    step();
    hs = cyc;
    awvalid = 1'b0;
    n_vec++;
    if (t >= BOUND) begin n_err++; $display("FAIL aw_accept: awready=%b after %0d cycles, required 1", awready, t); end
  endtask

  task automatic w_issue(input logic [31:0] d, input logic [3:0] s, output int hs);
    int t = 0;
    wdata = d;
    wstrb = s;
    wvalid = 1'b1;
    while (wready !== 1'b1 && t < BOUND) begin step(); t++; end
    step();
    hs = cyc;
    wvalid = 1'b0;
    n_vec++;
    if (t >= BOUND) begin n_err++; $display("FAIL w_accept: wready=%b after %0d cycles, required 1", wready, t); end
  endtask

  task automatic write_issue(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int lead, output int hs);
    int hs_aw, hs_w;
    fork
      begin repeat (lead) step(); aw_issue(a, hs_aw); end
      w_issue(d, s, hs_w);
    join
    hs = (hs_aw > hs_w) ? hs_aw : hs_w;
  endtask

  task automatic wait_b(input int hs, output int dly, output logic [1:0] resp);
    int t = 0;
    while (bvalid !== 1'b1 && t < BOUND) begin step(); t++; end
    dly = cyc - hs;
    resp = bresp;
    n_vec++;
    if (t >= BOUND) begin n_err++; $display("FAIL b_wait: bvalid=%b after %0d cycles, required 1", bvalid, t); end
  endtask

  task automatic b_ack();
    bready = 1'b1;
    step();
    bready = 1'b0;
  endtask

  task automatic ar_issue(input logic [31:0] a, output int hs);
    int t = 0;
    araddr = a;
    arvalid = 1'b1;
    while (arready !== 1'b1 && t < BOUND) begin step(); t++; end
    step();
    hs = cyc;
    arvalid = 1'b0;
    n_vec++;
    if (t >= BOUND) begin n_err++; $display("FAIL ar_accept: arready=%b after %0d cycles, required 1", arready, t); end
  endtask

  task automatic wait_r(input int hs, output int dly, output logic [31:0] data, output logic [1:0] resp);
    int t = 0;
    while (rvalid !== 1'b1 && t < BOUND) begin step(); t++; end
    dly = cyc - hs;
    data = rdata;
    resp = rresp;
    n_vec++;
    if (t >= BOUND) begin n_err++; $display("FAIL r_wait: rvalid=%b after %0d cycles, required 1", rvalid, t); end
  endtask

  task automatic r_ack();
    rready = 1'b1;
    step();
    rready = 1'b0;
  endtask

  // Full directed write then read on the fixed-delay instance, checking every field.
  task automatic chk_write(input string nm, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, input int lead, input logic [1:0] exp_resp);
    int hs, dly;
    logic [1:0] resp;
    write_issue(a, d, s, lead, hs);
    wait_b(hs, dly, resp);
    n_vec++;
    if (dly !== 3 || resp !== exp_resp) begin
      n_err++;
      $display("FAIL %s_b: delay=%0d bresp=%b, required delay=3 bresp=%b", nm, dly, resp, exp_resp);
    end
    b_ack();
  endtask

  task automatic chk_read(input string nm, input logic [31:0] a, input logic [31:0] exp_data,
                          input logic [1:0] exp_resp);
    int hs, dly;
    logic [31:0] data;
    logic [1:0] resp;
    ar_issue(a, hs);
    wait_r(hs, dly, data, resp);
    n_vec++;
    if (dly !== 3 || data !== exp_data || resp !== exp_resp) begin
      n_err++;
      $display("FAIL %s_r: delay=%0d rdata=%h rresp=%b, required delay=3 rdata=%h rresp=%b",
               nm, dly, data, resp, exp_data, exp_resp);
    end
    r_ack();
  endtask

  task automatic test_reset();
    areset = 1'b1;
    repeat (2) step();
    for (int k = 0; k < 2; k++) begin
      sel = k[0];
      #1;
      n_vec++;
      if ({awready, wready, arready, bvalid, rvalid, bresp, rresp, rdata} !== '0) begin
        n_err++;
        $display("FAIL reset_outputs[%0d]: ready/valid=%b%b%b%b%b bresp=%b rresp=%b rdata=%h, required all 0",
                 k, awready, wready, arready, bvalid, rvalid, bresp, rresp, rdata);
      end
    end
    sel = 1'b0;
    areset = 1'b0;
    step();
    for (int k = 0; k < 2; k++) begin
      sel = k[0];
      #1;
      n_vec++;
      if ({awready, wready, arready} !== 3'b111) begin
        n_err++;
        $display("FAIL idle_ready[%0d]: aw/w/ar ready=%b%b%b, required 111", k, awready, wready, arready);
      end
    end
    sel = 1'b0;
    step();
  endtask

  task automatic test_basic();
    sel = 1'b0;
    chk_write("basic", 32'h10, 32'hDEAD_BEEF, 4'hF, 0, RESP_OKAY);
    chk_read("basic", 32'h10, 32'hDEAD_BEEF, RESP_OKAY);
  endtask

  task automatic test_strobe();
    sel = 1'b0;
    chk_write("strb_fill", 32'h20, 32'hFFFF_FFFF, 4'hF, 0, RESP_OKAY);
    chk_write("strb_part", 32'h20, 32'h1234_5678, 4'b0011, 4, RESP_OKAY);
    chk_read("strb", 32'h20, 32'hFFFF_5678, RESP_OKAY);
  endtask

  task automatic test_bounds();
    sel = 1'b0;
    chk_write("oor", RNG + 32'h1, 32'hCAFE_F00D, 4'hF, 0, RESP_SLVERR);
    chk_read("oor_alias", 32'h0, 32'h0, RESP_OKAY);
    chk_read("oor", RNG + 32'h1, 32'h0, RESP_SLVERR);
    chk_write("last", 32'h00FF_FFFC, 32'h5A5A_A5A5, 4'hF, 0, RESP_OKAY);
    chk_read("last", 32'h00FF_FFFC, 32'h5A5A_A5A5, RESP_OKAY);
    chk_read("wrap", 32'h0000_03FC, 32'h5A5A_A5A5, RESP_OKAY);
  endtask

  task automatic test_b_hold();
    int hs, dly;
    logic [1:0] resp;
    sel = 1'b0;
    write_issue(32'h30, 32'h0BAD_CAFE, 4'hF, 0, hs);
    wait_b(hs, dly, resp);
    for (int i = 0; i < 10; i++) begin
      step();
      n_vec++;
      if ({bvalid, bresp, awready} !== {1'b1, RESP_OKAY, 1'b0}) begin
        n_err++;
        $display("FAIL b_hold[%0d]: bvalid=%b bresp=%b awready=%b, required 1 00 0", i, bvalid, bresp, awready);
      end
    end
    b_ack();
    n_vec++;
    if ({bvalid, awready, wready} !== 3'b011) begin
      n_err++;
      $display("FAIL b_release: bvalid=%b awready=%b wready=%b, required 0 1 1", bvalid, awready, wready);
    end
  endtask

  task automatic test_reset_mid();
    int hs;
    sel = 1'b0;
    ar_issue(32'h10, hs);
    step();
    areset = 1'b1;
    #2;
    for (int i = 0; i < 3; i++) begin
      n_vec++;
      if ({arready, rvalid} !== 2'b00) begin
        n_err++;
        $display("FAIL mid_reset[%0d]: arready=%b rvalid=%b, required 0 0", i, arready, rvalid);
      end
      step();
    end
    areset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      n_vec++;
      if (rvalid !== 1'b0) begin
        n_err++;
        $display("FAIL post_reset_rvalid[%0d]: rvalid=%b, required 0", i, rvalid);
      end
    end
    chk_read("post_reset", 32'h10, 32'h0, RESP_OKAY);
  endtask

  function automatic logic [31:0] pick_addr();
    if ($urandom_range(0, 7) == 0) return 32'h0100_0000 + ($urandom & 32'h00FF_FFFC);
    return $urandom & 32'h00FF_FFFC;
  endfunction

  task automatic test_random();
    logic [31:0] mdl [DEPTH];
    sel = 1'b1;
    for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
    for (int it = 0; it < 1000; it++) begin
      logic [31:0] wa, ra, wd, exp_rd, got_rd;
      logic [3:0]  ws;
      logic [1:0]  exp_br, exp_rr, got_br, got_rr;
      int          hs_w, hs_r, dw, dr, lead;
      wa = pick_addr();
      ra = pick_addr();
      while (in_win(wa) && in_win(ra) && widx(ra) == widx(wa)) ra = pick_addr();
      wd = $urandom;
      ws = 4'($urandom);
      lead = $urandom_range(0, 2);
      exp_br = in_win(wa) ? RESP_OKAY : RESP_SLVERR;
      exp_rr = in_win(ra) ? RESP_OKAY : RESP_SLVERR;
      exp_rd = in_win(ra) ? mdl[widx(ra)] : 32'h0;
      fork
        begin
          write_issue(wa, wd, ws, lead, hs_w);
          wait_b(hs_w, dw, got_br);
          n_vec++;
          if (got_br !== exp_br || dw < 2 || dw > 17) begin
            n_err++;
            $display("FAIL rnd_b[%0d]: addr=%h bresp=%b delay=%0d, required bresp=%b delay 2..17",
                     it, wa, got_br, dw, exp_br);
          end
          repeat ($urandom_range(0, 2)) step();
          b_ack();
        end
        begin
          ar_issue(ra, hs_r);
          wait_r(hs_r, dr, got_rd, got_rr);
          n_vec++;
          if (got_rd !== exp_rd || got_rr !== exp_rr || dr < 2 || dr > 17) begin
            n_err++;
            $display("FAIL rnd_r[%0d]: addr=%h rdata=%h rresp=%b delay=%0d, required rdata=%h rresp=%b delay 2..17",
                     it, ra, got_rd, got_rr, dr, exp_rd, exp_rr);
          end
          repeat ($urandom_range(0, 2)) step();
          r_ack();
        end
      join
      if (in_win(wa)) begin
        for (int b = 0; b < 4; b++) begin
          if (ws[b]) mdl[widx(wa)][b*8 +: 8] = wd[b*8 +: 8];
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_strobe();
    test_bounds();
    test_b_hold();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1);
  end

endmodule
